// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int unsigned REG_ZERO = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned x = value - 1; x > 0; x = x >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks clr_idx from 1 to NUM_REGS-1, zeroing one entry per cycle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx,
    output logic          hilo_clr,
    output logic          ready
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    // Next-state: advance through entries while clearing, arm a new pass on request.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NUM_REGS - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            RF_IDLE: begin
                if (clear_req) begin
                    state_d   = RF_CLEAR;
                    clr_idx_d = AW'(1);
                end
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_idx_d = AW'(1);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign clr_en   = (state_q == RF_CLEAR) && !reset;
    assign clr_idx  = clr_idx_q;
    assign hilo_clr = reset || ((state_q == RF_IDLE) && clear_req);
    assign ready    = (state_q == RF_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with $hi/$lo, dual write ports, optional bypass and a clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     ready,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     hilo_we,
    input  logic [2*DATA_W-1:0]      hilo_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]        hi_out,
    output logic [DATA_W-1:0]        lo_out
);

    localparam bit BYP = (BYPASS != 0);

    logic              clr_en;
    logic [AW-1:0]     clr_idx;
    logic              hilo_clr;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    regfile_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .hilo_clr  (hilo_clr),
        .ready     (ready)
    );

    // Write port 1 is applied after port 0 so the younger instruction wins a collision.
    always_comb begin
        mem_d = mem_q;
        if (ready) begin
            if (wr0_en && (wr0_addr != AW'(REG_ZERO))) begin
                mem_d[wr0_addr] = wr0_data;
            end
            if (wr1_en && (wr1_addr != AW'(REG_ZERO))) begin
                mem_d[wr1_addr] = wr1_data;
            end
        end
        if (clr_en) begin
            mem_d[clr_idx] = '0;
        end
        mem_d[REG_ZERO] = '0;
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (ready && hilo_we) begin
            hi_d = hilo_data[2*DATA_W-1:DATA_W];
            lo_d = hilo_data[DATA_W-1:0];
        end
        if (hilo_clr) begin
            hi_d = '0;
            lo_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Per-port read mux: zero register, then wr1, then wr0, then storage.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = '0;
            if (ready && (addr != AW'(REG_ZERO))) begin
                data = mem_q[addr];
                if (BYP) begin
                    if (wr0_en && (wr0_addr == addr)) begin
                        data = wr0_data;
                    end
                    if (wr1_en && (wr1_addr == addr)) begin
                        data = wr1_data;
                    end
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

    assign hi_out = !ready ? '0 : ((BYP && hilo_we) ? hilo_data[2*DATA_W-1:DATA_W] : hi_q);
    assign lo_out = !ready ? '0 : ((BYP && hilo_we) ? hilo_data[DATA_W-1:0] : lo_q);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized checks of regfile_mp against a behavioural model.
module tb_regfile_mp;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned NUM_RD   = 2;
    localparam int unsigned AW       = 5;

    logic                     clock;
    logic                     reset;
    logic                     clear_req;
    logic                     ready;
    logic                     wr0_en;
    logic [AW-1:0]            wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [AW-1:0]            wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     hilo_we;
    logic [2*DATA_W-1:0]      hilo_data;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]        hi_out;
    logic [DATA_W-1:0]        lo_out;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (ready),
        .wr0_en    (wr0_en),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .hilo_we   (hilo_we),
        .hilo_data (hilo_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents plus edges left until usable.
    logic [DATA_W-1:0] mdl [NUM_REGS];
    logic [DATA_W-1:0] mdl_hi;
    logic [DATA_W-1:0] mdl_lo;
    int                busy = NUM_REGS - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [AW-1:0] a);
        if (busy != 0 || a == 0) return '0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return mdl[a];
    endfunction

    task automatic check_all(input string tag);
        logic [AW-1:0] a;
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*AW +: AW];
            chk($sformatf("%s_rd%0d_a%0d", tag, k, a), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_rd(a)));
        end
        chk({tag, "_ready"}, 64'(ready), 64'(busy == 0));
        if (busy != 0) begin
            chk({tag, "_hi"}, 64'(hi_out), 64'd0);
            chk({tag, "_lo"}, 64'(lo_out), 64'd0);
        end else if (hilo_we) begin
            chk({tag, "_hi"}, 64'(hi_out), 64'(hilo_data[63:32]));
            chk({tag, "_lo"}, 64'(lo_out), 64'(hilo_data[31:0]));
        end else begin
            chk({tag, "_hi"}, 64'(hi_out), 64'(mdl_hi));
            chk({tag, "_lo"}, 64'(lo_out), 64'(mdl_lo));
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        mdl_hi = '0;
        mdl_lo = '0;
    endtask

    // One clock edge: update the model from the inputs presented before it.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            busy = NUM_REGS - 1;
            zero_model();
        end else if (busy > 0) begin
            busy--;
        end else begin
            if (wr0_en && wr0_addr != 0) mdl[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) mdl[wr1_addr] = wr1_data;
            if (hilo_we) begin
                mdl_hi = hilo_data[63:32];
                mdl_lo = hilo_data[31:0];
            end
            if (clear_req) begin
                busy = NUM_REGS - 1;
                zero_model();
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 0;
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        hilo_we = 0; hilo_data = '0;
    endtask

    task automatic wait_ready(input string tag, input int start_count);
        int n;
        n = start_count;
        while (!ready && n < 100) begin
            #1 check_all({tag, "_busy"});
            tick();
            n++;
        end
        chk({tag, "_edges"}, 64'(n), 64'(NUM_REGS - 1));
    endtask

    initial begin
        zero_model();
        idle_inputs();
        rd_addr = '0;
        reset = 1;
        for (int i = 0; i < 3; i++) tick();
        check_all("rst");
        chk("rst_ready", 64'(ready), 64'd0);
        reset = 0;
        wait_ready("init", 0);

        for (int a = 0; a < NUM_REGS; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            #1 check_all("init_zero");
        end

        // Same-address collision: younger write wins.
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1111;
        wr1_en = 1; wr1_addr = 5; wr1_data = 32'h2222;
        rd_addr = {AW'(5), AW'(5)};
        #1 chk("coll_byp", 64'(rd_data[31:0]), 64'h2222);
        check_all("coll");
        tick();
        idle_inputs();
        #1 chk("coll_store", 64'(rd_data[31:0]), 64'h2222);

        // r0 stays zero.
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hDEAD;
        rd_addr = {AW'(5), AW'(0)};
        #1 chk("r0_same", 64'(rd_data[31:0]), 64'd0);
        tick();
        idle_inputs();
        #1 chk("r0_next", 64'(rd_data[31:0]), 64'd0);

        // hi/lo write with bypass and persistence.
        hilo_we = 1; hilo_data = 64'h00000001_FFFFFFFE;
        #1 chk("hi_byp", 64'(hi_out), 64'h1);
        chk("lo_byp", 64'(lo_out), 64'hFFFFFFFE);
        tick();
        idle_inputs();
        #1 chk("hi_hold", 64'(hi_out), 64'h1);
        chk("lo_hold", 64'(lo_out), 64'hFFFFFFFE);

        // Clear request drops writes and wipes state.
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h55;
        tick();
        idle_inputs();
        rd_addr = {AW'(9), AW'(7)};
        #1 chk("r7_load", 64'(rd_data[31:0]), 64'h55);
        clear_req = 1;
        #1 check_all("creq");
        tick();
        clear_req = 0;
        chk("creq_fall", 64'(ready), 64'd0);
        wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99;
        #1 check_all("clr_wr");
        tick();
        idle_inputs();
        wait_ready("creq", 1);
        #1 check_all("post_clr");
        chk("post_clr_r7", 64'(rd_data[31:0]), 64'd0);
        chk("post_clr_r9", 64'(rd_data[63:32]), 64'd0);
        chk("post_clr_hi", 64'(hi_out), 64'd0);

        // Reset midway through a clear restarts the sequence.
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1;
        tick();
        reset = 0;
        wait_ready("midrst", 0);

        // Randomized traffic with clustered addresses to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            clear_req = ($urandom_range(0, 59) == 0);
            wr0_en    = $urandom_range(0, 1) == 1;
            wr1_en    = $urandom_range(0, 1) == 1;
            wr0_addr  = AW'($urandom_range(0, 7));
            wr1_addr  = AW'($urandom_range(0, 7));
            wr0_data  = $urandom;
            wr1_data  = $urandom;
            hilo_we   = ($urandom_range(0, 3) == 0);
            hilo_data = {$urandom, $urandom};
            rd_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31))};
            #1 check_all("rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
